control_unit: RTL and testbench

Multi-cycle fetch/decode/execute/writeback sequencer that drives the register-file/ALU datapath of the core. It fetches 16-bit instructions from a synchronous instruction memory, steers the datapath's register addresses, ALU opcode and write port, latches ALU flags, and resolves branches. It sits between the instruction memory and the datapath and is the only writer of the datapath control inputs.

---
 rtl/control_unit_pkg.sv | 38 +++
 rtl/control_unit_instr_decode.sv | 23 ++
 rtl/control_unit.sv | 141 ++++++++++++++
 tb/tb_control_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared types and constants for the control_unit sequencer.
// FSM states, opcode classes, instruction field positions.
package control_unit_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } state_e;

   localparam logic [3:0] OP_ALU_MAX = 4'hB;
   localparam logic [3:0] OP_LDI     = 4'hC;
   localparam logic [3:0] OP_BZ      = 4'hD;
   localparam logic [3:0] OP_JMP     = 4'hE;
   localparam logic [3:0] OP_HALT    = 4'hF;

   localparam int OP_LSB  = 12;
   localparam int RD_LSB  = 8;
   localparam int RA_LSB  = 4;
   localparam int RB_LSB  = 0;
   localparam int IMM_LSB = 0;

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] rd;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [7:0] imm;
      logic       is_alu;
      logic       is_ldi;
      logic       is_branch;
      logic       is_halt;
   } dec_t;

endpackage

// File: rtl/control_unit_instr_decode.sv
// Combinational instruction decoder: field split and class flags.
module instr_decode
   import control_unit_pkg::*;
(
   input  logic [15:0] ir_i,
   output dec_t        dec_o
);

   logic [3:0] op;

   assign op = ir_i[OP_LSB +: 4];

   assign dec_o.op        = op;
   assign dec_o.rd        = ir_i[RD_LSB +: 4];
   assign dec_o.ra        = ir_i[RA_LSB +: 4];
   assign dec_o.rb        = ir_i[RB_LSB +: 4];
   assign dec_o.imm       = ir_i[IMM_LSB +: 8];
   assign dec_o.is_alu    = (op <= OP_ALU_MAX);
   assign dec_o.is_ldi    = (op == OP_LDI);
   assign dec_o.is_branch = (op == OP_BZ) || (op == OP_JMP);
   assign dec_o.is_halt   = (op == OP_HALT);

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute/writeback sequencer for the reg-file/ALU datapath.
// Outputs are registered from the next state so they align with it.
module control_unit
   import control_unit_pkg::*;
#(
   parameter int unsigned         PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   output logic [PC_WIDTH-1:0] imem_addr,
   output logic                imem_rd,
   input  logic [15:0]         imem_data,
   input  logic [7:0]          alu_result,
   input  logic                alu_zero,
   input  logic                alu_carry,
   output logic [3:0]          alu_opcode,
   output logic [3:0]          ra_addr,
   output logic [3:0]          rb_addr,
   output logic [3:0]          write_addr,
   output logic [7:0]          write_data,
   output logic                write_en,
   output logic [PC_WIDTH-1:0] pc,
   output logic                zero_flag,
   output logic                carry_flag,
   output logic                halted
);

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [15:0]         ir_q, ir_d;
   logic [7:0]          res_q, res_d;
   logic                zf_q, zf_d;
   logic                cf_q, cf_d;
   dec_t                dec;

   logic [PC_WIDTH-1:0] iaddr_q;
   logic                ird_q;
   logic [3:0]          opc_q, ra_q, rb_q, wa_q;
   logic [7:0]          wd_q;
   logic                we_q, halted_q;

   // Decode the word that will sit in ir next cycle.
   assign ir_d = (state_q == S_DECODE) ? imem_data : ir_q;

   instr_decode u_dec (
      .ir_i  (ir_d),
      .dec_o (dec)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      res_d   = res_q;
      zf_d    = zf_q;
      cf_d    = cf_q;
      unique case (state_q)
         S_IDLE:   if (run) state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            pc_d    = pc_q + PC_WIDTH'(1);
            state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            unique case (1'b1)
               dec.is_alu: begin
                  res_d   = alu_result;
                  zf_d    = alu_zero;
                  cf_d    = alu_carry;
                  state_d = S_WRITEBACK;
               end
               dec.is_ldi: begin
                  res_d   = dec.imm;
                  state_d = S_WRITEBACK;
               end
               dec.is_branch: begin
                  if ((dec.op == OP_JMP) || zf_q)
                     pc_d = PC_WIDTH'(dec.imm);
                  state_d = S_FETCH;
               end
               dec.is_halt: state_d = S_HALT;
               default:     state_d = S_IDLE;
            endcase
         end
         S_WRITEBACK: state_d = S_FETCH;
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         res_q    <= '0;
         zf_q     <= 1'b0;
         cf_q     <= 1'b0;
         iaddr_q  <= '0;
         ird_q    <= 1'b0;
         opc_q    <= '0;
         ra_q     <= '0;
         rb_q     <= '0;
         wa_q     <= '0;
         wd_q     <= '0;
         we_q     <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         res_q    <= res_d;
         zf_q     <= zf_d;
         cf_q     <= cf_d;
         ird_q    <= (state_d == S_FETCH);
         iaddr_q  <= (state_d == S_FETCH) ? pc_d : '0;
         opc_q    <= (state_d == S_EXECUTE) ? dec.op : '0;
         ra_q     <= (state_d == S_EXECUTE) ? dec.ra : '0;
         rb_q     <= (state_d == S_EXECUTE) ? dec.rb : '0;
         we_q     <= (state_d == S_WRITEBACK);
         wa_q     <= (state_d == S_WRITEBACK) ? dec.rd : '0;
         wd_q     <= (state_d == S_WRITEBACK) ? res_d : '0;
         halted_q <= (state_d == S_HALT);
      end
   end

   assign imem_addr  = iaddr_q;
   assign imem_rd    = ird_q;
   assign alu_opcode = opc_q;
   assign ra_addr    = ra_q;
   assign rb_addr    = rb_q;
   assign write_addr = wa_q;
   assign write_data = wd_q;
   assign write_en   = we_q;
   assign pc         = pc_q;
   assign zero_flag  = zf_q;
   assign carry_flag = cf_q;
   assign halted     = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench: instruction-level model predicts fetches and writes.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [7:0]  imem_addr;
   logic        imem_rd;
   logic [15:0] imem_data;
   logic [7:0]  alu_result;
   logic        alu_zero, alu_carry;
   logic [3:0]  alu_opcode, ra_addr, rb_addr, write_addr;
   logic [7:0]  write_data;
   logic        write_en;
   logic [7:0]  pc;
   logic        zero_flag, carry_flag, halted;

   always #5 clk = ~clk;

   control_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .run(run),
      .imem_addr(imem_addr), .imem_rd(imem_rd),
      .imem_data(imem_data),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .alu_carry(alu_carry), .alu_opcode(alu_opcode),
      .ra_addr(ra_addr), .rb_addr(rb_addr),
      .write_addr(write_addr), .write_data(write_data),
      .write_en(write_en), .pc(pc),
      .zero_flag(zero_flag), .carry_flag(carry_flag),
      .halted(halted)
   );

   logic [15:0] mem [256];
   logic [7:0]  rf  [16];
   int          cyc = 0;

   function automatic logic [8:0] alu_f(input logic [3:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
      case (op)
         4'h0:    return {1'b0, a} + {1'b0, b};
         4'h1:    return {1'b0, a} - {1'b0, b};
         4'h2:    return {1'b0, a & b};
         4'h3:    return {1'b0, a | b};
         4'h4:    return {1'b0, a ^ b};
         4'h5:    return {a, 1'b0};
         4'h6:    return {a[0], 1'b0, a[7:1]};
         4'h7:    return {1'b0, a};
         4'h8:    return {1'b0, ~a};
         4'h9:    return {1'b0, a} + 9'd1;
         4'hA:    return {1'b0, a} - 9'd1;
         default: return {1'b0, b};
      endcase
   endfunction

   logic [8:0] alu_full;
   assign alu_full   = alu_f(alu_opcode, rf[ra_addr], rf[rb_addr]);
   assign alu_result = alu_full[7:0];
   assign alu_carry  = alu_full[8];
   assign alu_zero   = (alu_full[7:0] == 8'h00);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (imem_rd) imem_data <= mem[imem_addr];
      if (write_en) rf[write_addr] <= write_data;
   end

   typedef struct {
      logic [7:0] addr;
      int         cyc;
   } fexp_t;
   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
      int         cyc;
   } wexp_t;

   fexp_t fq[$];
   wexp_t wq[$];
   int    tests = 0;
   int    errs  = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin : monitor
      fexp_t f;
      wexp_t w;
      forever begin
         @(negedge clk);
         if (imem_rd && fq.size() > 0) begin
            f = fq.pop_front();
            check("fetch_addr", imem_addr, f.addr);
            check("fetch_cycle", cyc, f.cyc);
         end
         if (write_en && wq.size() > 0) begin
            w = wq.pop_front();
            check("wr_addr", write_addr, w.addr);
            check("wr_data", write_data, w.data);
            check("wr_cycle", cyc, w.cyc);
         end
      end
   end

   logic [7:0] m_rf [16];
   logic [7:0] m_pc;
   logic       m_z, m_c, m_halt;

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      fq.delete();
      wq.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic fill_halt();
      for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
   endtask

   task automatic fill_rand();
      logic [3:0] op;
      for (int i = 0; i < 256; i++) begin
         op = 4'($urandom_range(0, 15));
         if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'hC;
         mem[i] = {op, 12'($urandom)};
      end
   endtask

   task automatic run_prog(input int k);
      int          t, n;
      logic [15:0] ins;
      logic [3:0]  op, rd;
      logic [7:0]  imm;
      logic [8:0]  r;
      do_reset();
      for (int i = 0; i < 16; i++) m_rf[i] = rf[i];
      m_pc = 8'h00; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
      t = cyc + 1;
      for (int s = 0; s < k && !m_halt; s++) begin
         fq.push_back('{m_pc, t});
         ins  = mem[m_pc];
         op   = ins[15:12];
         rd   = ins[11:8];
         imm  = ins[7:0];
         m_pc = m_pc + 8'd1;
         if (op <= 4'hB) begin
            r = alu_f(op, m_rf[ins[7:4]], m_rf[ins[3:0]]);
            m_z = (r[7:0] == 8'h00);
            m_c = r[8];
            m_rf[rd] = r[7:0];
            wq.push_back('{rd, r[7:0], t + 3});
            t += 4;
         end else if (op == 4'hC) begin
            m_rf[rd] = imm;
            wq.push_back('{rd, imm, t + 3});
            t += 4;
         end else if (op == 4'hD) begin
            if (m_z) m_pc = imm;
            t += 3;
         end else if (op == 4'hE) begin
            m_pc = imm;
            t += 3;
         end else begin
            m_halt = 1'b1;
         end
      end
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      n = 0;
      while ((fq.size() + wq.size()) > 0 && n < 4 * k + 20) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", fq.size() + wq.size(), 0);
      fq.delete();
      wq.delete();
      if (m_halt) begin
         repeat (3) @(negedge clk);
         check("halted", halted, 1);
         check("halt_pc", pc, m_pc);
         check("halt_zf", zero_flag, m_z);
         check("halt_cf", carry_flag, m_c);
         run = 1'b1;
         @(negedge clk);
         run = 1'b0;
         check("halt_no_fetch", imem_rd, 0);
         @(negedge clk);
         check("halt_sticky", halted, 1);
      end
   endtask

   initial begin : stim
      int n;
      bit found;
      fill_halt();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_rd", imem_rd, 0);
      check("rst_we", write_en, 0);
      check("rst_pc", pc, 0);
      check("rst_flags", {zero_flag, carry_flag, halted}, 0);
      check("rst_ports", {imem_addr, alu_opcode, ra_addr,
                          rb_addr, write_addr, write_data}, 0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_rd", imem_rd, 0);
         check("idle_we", write_en, 0);
         check("idle_pc", pc, 0);
      end

      fill_halt();
      mem[0] = 16'hC35A;
      run_prog(4);

      fill_halt();
      mem[0] = 16'hC1FF;
      mem[1] = 16'hC201;
      mem[2] = 16'h0412;
      mem[3] = 16'hD010;
      mem[4] = 16'hC999;
      run_prog(8);

      fill_halt();
      mem[0] = 16'hC101;
      mem[1] = 16'hC201;
      mem[2] = 16'h0412;
      mem[3] = 16'hD010;
      mem[4] = 16'hC4AB;
      run_prog(8);

      fill_halt();
      mem[0]     = 16'hE0FF;
      mem[8'hFF] = 16'h0112;
      run_prog(5);

      for (int p = 0; p < 25; p++) begin
         fill_rand();
         run_prog(30);
      end

      fill_halt();
      mem[0] = 16'hC1FF;
      mem[1] = 16'hC201;
      mem[2] = 16'h0412;
      do_reset();
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      found = 1'b0;
      n = 0;
      while (!found && n < 40) begin
         @(negedge clk);
         n++;
         if (write_en && write_addr == 4'd4) found = 1'b1;
      end
      check("wb_seen", found, 1);
      check("wb_zf", zero_flag, 1);
      check("wb_cf", carry_flag, 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_we", write_en, 0);
      check("mid_rst_pc", pc, 0);
      check("mid_rst_flags", {zero_flag, carry_flag}, 0);
      check("mid_rst_rd", imem_rd, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_idle", imem_rd, 0);

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
